// File: rtl/orb_desc_xor_slicer.sv
// XOR a query/candidate ORB descriptor pair and stream the difference as
// SLICE_W-bit slices. Optional stall input enabled by macro ORB_SLICE_HOLD_EN.
module orb_desc_xor_slicer #(
  parameter int DESC_W  = 256,
  parameter int SLICE_W = 16,
  parameter int TAG_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [DESC_W-1:0]  i_desc_a,
  input  logic [DESC_W-1:0]  i_desc_b,
  input  logic [TAG_W-1:0]   i_tag,
`ifdef ORB_SLICE_HOLD_EN
  input  logic               i_hold,
`endif
  output logic               o_accept,
  output logic               o_ready,
  output logic [SLICE_W-1:0] o_value,
  output logic               o_first,
  output logic               o_last,
  output logic [TAG_W-1:0]   o_tag,
  output logic               o_overrun
);

  localparam int NUM_SLICES = DESC_W / SLICE_W;
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DESC_W-1:0]  x_q, x_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               ready_q, ready_d;
  logic [SLICE_W-1:0] value_q, value_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic [TAG_W-1:0]   otag_q, otag_d;
  logic               overrun_q, overrun_d;

  logic               hold_s;
  logic               accept_s;
  logic               take_s;
  logic               at_last_s;
  logic [SLICE_W-1:0] slice_s;

`ifdef ORB_SLICE_HOLD_EN
  assign hold_s = i_hold;
`else
  assign hold_s = 1'b0;
`endif

  assign at_last_s = (idx_q == LAST_IDX);
  // A new pair can be taken while the final slice of the current one is being registered.
  assign accept_s  = (state_q == ST_IDLE) || ((state_q == ST_EMIT) && at_last_s && !hold_s);
  assign take_s    = i_valid && accept_s;
  assign slice_s   = x_q[int'(idx_q) * SLICE_W +: SLICE_W];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    x_d       = x_q;
    tag_d     = tag_q;
    ready_d   = 1'b0;
    value_d   = value_q;
    first_d   = 1'b0;
    last_d    = 1'b0;
    otag_d    = otag_q;
    overrun_d = i_valid && !accept_s;

    case (state_q)
      ST_IDLE: begin
        if (take_s) begin
          x_d     = i_desc_a ^ i_desc_b;
          tag_d   = i_tag;
          idx_d   = '0;
          state_d = ST_EMIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (!hold_s) begin
          ready_d = 1'b1;
          value_d = slice_s;
          first_d = (idx_q == '0);
          last_d  = at_last_s;
          otag_d  = tag_q;
          if (at_last_s) begin
            idx_d = '0;
            if (take_s) begin
              x_d     = i_desc_a ^ i_desc_b;
              tag_d   = i_tag;
              state_d = ST_EMIT;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      x_q       <= '0;
      tag_q     <= '0;
      ready_q   <= 1'b0;
      value_q   <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      otag_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      x_q       <= x_d;
      tag_q     <= tag_d;
      ready_q   <= ready_d;
      value_q   <= value_d;
      first_q   <= first_d;
      last_q    <= last_d;
      otag_q    <= otag_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_accept  = accept_s;
  assign o_ready   = ready_q;
  assign o_value   = value_q;
  assign o_first   = first_q;
  assign o_last    = last_q;
  assign o_tag     = otag_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_orb_desc_xor_slicer.sv
// Self-checking bench for orb_desc_xor_slicer: directed table, corner sequences, random traffic.
module tb_orb_desc_xor_slicer;

  localparam int DW = 256;
  localparam int SW = 16;
  localparam int TW = 8;
  localparam int NS = DW / SW;

  logic          clk;
  logic          i_rst;
  logic          i_valid;
  logic [DW-1:0] i_desc_a;
  logic [DW-1:0] i_desc_b;
  logic [TW-1:0] i_tag;
  logic          hold_v;
  logic          o_accept, o_ready, o_first, o_last, o_overrun;
  logic [SW-1:0] o_value;
  logic [TW-1:0] o_tag;

  orb_desc_xor_slicer #(.DESC_W(DW), .SLICE_W(SW), .TAG_W(TW)) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .i_desc_a  (i_desc_a),
    .i_desc_b  (i_desc_b),
    .i_tag     (i_tag),
`ifdef ORB_SLICE_HOLD_EN
    .i_hold    (hold_v),
`endif
    .o_accept  (o_accept),
    .o_ready   (o_ready),
    .o_value   (o_value),
    .o_first   (o_first),
    .o_last    (o_last),
    .o_tag     (o_tag),
    .o_overrun (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] v;
    logic          first;
    logic          last;
    logic [TW-1:0] tag;
  } slice_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [TW-1:0] tag;
    int            exp_pop;
    logic [SW-1:0] exp_s1;
  } vec_t;

  // Reference model: slices still owed downstream, and the expected stream itself.
  slice_t        exp_q[$];
  int            rem;
  logic [SW-1:0] exp_value;
  logic [TW-1:0] exp_tag;

  int n_vec, n_bad;
  int pop_sum, strobes, firsts, lasts, overruns, cur_run, max_run;
  logic [SW-1:0] seen_s1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd256();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TW-1:0] t);
    logic [DW-1:0] x;
    slice_t s;
    x = a ^ b;
    for (int k = 0; k < NS; k++) begin
      s.v     = SW'(x >> (k * SW));
      s.first = (k == 0);
      s.last  = (k == NS - 1);
      s.tag   = t;
      exp_q.push_back(s);
    end
  endtask

  task automatic clear_stats();
    pop_sum = 0; strobes = 0; firsts = 0; lasts = 0; overruns = 0;
    cur_run = 0; max_run = 0; seen_s1 = '0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    rem       = 0;
    exp_value = '0;
    exp_tag   = '0;
  endtask

  // One clock: check the combinational accept, advance the model, then check registered outputs.
  task automatic step(output bit took);
    bit acc_m, ovr_m, v_in, h_in, er, ef, el;
    logic [DW-1:0] a_in, b_in;
    logic [TW-1:0] t_in;
    slice_t s;
    #1;
    h_in = hold_v; v_in = i_valid; a_in = i_desc_a; b_in = i_desc_b; t_in = i_tag;
    acc_m = (rem == 0) || (rem == 1 && !h_in);
    ovr_m = v_in && !acc_m;
    chk("accept", o_accept, acc_m);
    @(posedge clk);
    er = 1'b0; ef = 1'b0; el = 1'b0;
    if (rem > 0 && !h_in) begin
      s = exp_q.pop_front();
      exp_value = s.v; exp_tag = s.tag;
      er = 1'b1; ef = s.first; el = s.last;
      rem--;
    end
    took = v_in && acc_m;
    if (took) begin
      push_pair(a_in, b_in, t_in);
      rem += NS;
    end
    #1;
    chk("ready", o_ready, er);
    chk("value", o_value, exp_value);
    chk("first", o_first, ef);
    chk("last", o_last, el);
    chk("tag", o_tag, exp_tag);
    chk("overrun", o_overrun, ovr_m);
    if (o_ready) begin
      if (strobes == 1) seen_s1 = o_value;
      pop_sum += $countones(o_value);
      strobes++;
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
    end else begin
      cur_run = 0;
    end
    if (o_first) firsts++;
    if (o_last) lasts++;
    if (o_overrun) overruns++;
  endtask

  task automatic drain();
    bit d;
    for (int c = 0; c < 4 * NS && rem > 0; c++) step(d);
    chk("drain_timeout", 256'(rem), 256'd0);
  endtask

  task automatic send_one(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TW-1:0] t);
    bit took;
    i_valid = 1'b1; i_desc_a = a; i_desc_b = b; i_tag = t;
    step(took);
    chk("send_took", 256'(took), 256'd1);
    i_valid = 1'b0;
  endtask

  vec_t tbl[4];

  initial begin
    logic [DW-1:0] pat;
    bit d, took;
    n_vec = 0; n_bad = 0;
    clear_stats();
    model_reset();
    pat = {4{64'h0123456789ABCDEF}};
    tbl[0] = '{a: '1, b: '0, tag: 8'h5A, exp_pop: 256, exp_s1: 16'hFFFF};
    tbl[1] = '{a: pat, b: pat ^ (256'd1 << 17), tag: 8'h3C, exp_pop: 1, exp_s1: 16'h0002};
    tbl[2] = '{a: pat, b: pat, tag: 8'h11, exp_pop: 0, exp_s1: 16'h0000};
    tbl[3] = '{a: '0, b: (256'd1 << 255) | 256'd1, tag: 8'hA5, exp_pop: 2, exp_s1: 16'h0000};

    i_rst = 1'b1; i_valid = 1'b0; i_desc_a = '0; i_desc_b = '0; i_tag = '0; hold_v = 1'b0;
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;
    #1;
    chk("rst_accept", o_accept, 1'b1);
    chk("rst_ready", o_ready, 1'b0);
    chk("rst_value", o_value, 16'h0000);
    chk("rst_tag", o_tag, 8'h00);
    chk("rst_overrun", o_overrun, 1'b0);
    step(d);

    // Directed table: single pairs with known popcount and slice 1.
    for (int i = 0; i < 4; i++) begin
      clear_stats();
      send_one(tbl[i].a, tbl[i].b, tbl[i].tag);
      drain();
      chk("tbl_popcount", 256'(pop_sum), 256'(tbl[i].exp_pop));
      chk("tbl_strobes", 256'(strobes), 256'(NS));
      chk("tbl_slice1", seen_s1, tbl[i].exp_s1);
      chk("tbl_firsts", 256'(firsts), 256'd1);
      chk("tbl_lasts", 256'(lasts), 256'd1);
      step(d);
    end

    // Back-to-back: second pair waits with i_valid high until taken.
    clear_stats();
    i_valid = 1'b1; i_desc_a = rnd256(); i_desc_b = rnd256(); i_tag = 8'h01;
    step(took);
    i_desc_a = rnd256(); i_desc_b = rnd256(); i_tag = 8'h02;
    took = 1'b0;
    for (int c = 0; c < 2 * NS && !took; c++) step(took);
    chk("b2b_second_taken", 256'(took), 256'd1);
    i_valid = 1'b0;
    drain();
    chk("b2b_strobes", 256'(strobes), 256'(2 * NS));
    chk("b2b_no_gap", 256'(max_run), 256'(2 * NS));
    step(d);

    // Overrun at idx 5: dropped pair must not disturb the stream.
    clear_stats();
    send_one(rnd256(), rnd256(), 8'h77);
    repeat (5) step(d);
    i_valid = 1'b1; i_desc_a = '1; i_desc_b = '0; i_tag = 8'hEE;
    step(took);
    chk("ovr_not_taken", 256'(took), 256'd0);
    i_valid = 1'b0;
    drain();
    chk("ovr_pulses", 256'(overruns), 256'd1);
    chk("ovr_strobes", 256'(strobes), 256'(NS));
    step(d);

    // Asynchronous reset at idx 9.
    clear_stats();
    send_one(rnd256(), rnd256(), 8'h99);
    repeat (9) step(d);
    i_rst = 1'b1;
    #2;
    chk("arst_ready", o_ready, 1'b0);
    chk("arst_last", o_last, 1'b0);
    chk("arst_value", o_value, 16'h0000);
    @(posedge clk);
    #1 i_rst = 1'b0;
    model_reset();
    chk("arst_lasts", 256'(lasts), 256'd0);
    step(d);

`ifdef ORB_SLICE_HOLD_EN
    // Hold for 3 cycles at idx 7.
    clear_stats();
    send_one(rnd256(), rnd256(), 8'h42);
    repeat (7) step(d);
    hold_v = 1'b1;
    repeat (3) step(d);
    hold_v = 1'b0;
    drain();
    chk("hold_strobes", 256'(strobes), 256'(NS));
    step(d);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      i_valid  = ($urandom_range(0, 2) == 0);
      i_desc_a = rnd256();
      i_desc_b = ($urandom_range(0, 3) == 0) ? i_desc_a ^ rnd256() : rnd256();
      i_tag    = TW'($urandom);
`ifdef ORB_SLICE_HOLD_EN
      hold_v   = ($urandom_range(0, 3) == 0);
`endif
      step(d);
    end
    i_valid = 1'b0;
    hold_v  = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
